// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the 8-bit internal bus with bounded hold time.
// Define ARB_LOCK_EN to add the lock port (owner may extend past MAX_HOLD).
module bus_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] req,
`ifdef ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [4:0] grant,
  output logic [2:0] bus_sel,
  output logic       bus_busy
);

  // Source index doubles as the bus mux code; 3'b111 parks the mux.
  localparam logic [2:0] SEL_IDLE = 3'b111;
  localparam logic [2:0] LAST_RST = 3'd4;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        owner_q, owner_d;
  logic [2:0]        last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [4:0]        grant_q, grant_d;
  logic [2:0]        sel_q, sel_d;
  logic              busy_q, busy_d;

  logic              lock_on;
  logic              own_req;
  logic [4:0]        others;
  logic [3:0]        pick_idle;
  logic [3:0]        pick_next;
  logic              take;
  logic [2:0]        take_idx;
  logic              drop;

`ifdef ARB_LOCK_EN
  assign lock_on = lock;
`else
  assign lock_on = 1'b0;
`endif

  // First requester after base, scanning base+1 .. base+5 mod 5.
  // Returns {found, index}.
  function automatic logic [3:0] rr_pick(
    input logic [4:0] r,
    input logic [2:0] base
  );
    logic [3:0] res;
    logic [2:0] k;
    res = 4'b0;
    for (int i = 5; i >= 1; i--) begin
      k = 3'((int'(base) + i) % 5);
      if (r[k]) res = {1'b1, k};
    end
    return res;
  endfunction

  assign own_req   = req[owner_q];
  assign others    = req & ~(5'b1 << owner_q);
  assign pick_idle = rr_pick(req, last_q);
  assign pick_next = rr_pick(others, owner_q);

  // Next-state: arbitration, release, preemption, hold counting.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    hold_d   = hold_q;
    grant_d  = grant_q;
    sel_d    = sel_q;
    busy_d   = busy_q;
    take     = 1'b0;
    take_idx = owner_q;
    drop     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pick_idle[3]) begin
          take     = 1'b1;
          take_idx = pick_idle[2:0];
        end
      end
      S_GRANT: begin
        if (!own_req) begin
          // Release wins over a same-edge preemption.
          last_d = owner_q;
          if (pick_next[3]) begin
            take     = 1'b1;
            take_idx = pick_next[2:0];
          end else begin
            drop = 1'b1;
          end
        end else if (|others && hold_q >= HOLD_LAST && !lock_on) begin
          // >= so an owner saturated while alone still yields.
          last_d   = owner_q;
          take     = 1'b1;
          take_idx = pick_next[2:0];
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: drop = 1'b1;
    endcase

    if (take) begin
      state_d = S_GRANT;
      owner_d = take_idx;
      hold_d  = '0;
      grant_d = 5'b1 << take_idx;
      sel_d   = take_idx;
      busy_d  = 1'b1;
    end else if (drop) begin
      state_d = S_IDLE;
      hold_d  = '0;
      grant_d = '0;
      sel_d   = SEL_IDLE;
      busy_d  = 1'b0;
    end
  end

  // State and registered outputs; reset drops ownership at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
      hold_q  <= '0;
      grant_q <= '0;
      sel_q   <= SEL_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
    end
  end

  assign grant    = grant_q;
  assign bus_sel  = sel_q;
  assign bus_busy = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: cycle-level ownership model plus directed checks.
// Lock scenario compiled only with ARB_LOCK_EN.
module tb_bus_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] req;
  logic       lock;
  logic [4:0] grant;
  logic [2:0] bus_sel;
  logic       bus_busy;

  int n_chk = 0;
  int n_fail = 0;

  // Model: current owner (-1 idle), last departed owner, cycles held.
  int m_own;
  int m_last;
  int m_held;

  bus_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
`ifdef ARB_LOCK_EN
    .lock     (lock),
`endif
    .grant    (grant),
    .bus_sel  (bus_sel),
    .bus_busy (bus_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int mpick(input logic [4:0] r, input int base);
    for (int i = 1; i <= 5; i++) begin
      if (r[(base + i) % 5]) return (base + i) % 5;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_own  = -1;
    m_last = 4;
    m_held = 0;
  endtask

  task automatic model_step(input logic [4:0] r, input logic lk);
    logic [4:0] oth;
    bit lk_en;
`ifdef ARB_LOCK_EN
    lk_en = lk;
`else
    lk_en = 1'b0;
    if (lk) lk_en = 1'b0;
`endif
    if (m_own < 0) begin
      m_own = mpick(r, m_last);
      m_held = 1;
    end else if (!r[m_own]) begin
      m_last = m_own;
      m_own = mpick(r, m_own);
      m_held = 1;
    end else begin
      oth = r & ~(5'b1 << m_own);
      if (oth != 0 && m_held >= MAX_HOLD && !lk_en) begin
        m_last = m_own;
        m_own = mpick(oth, m_own);
        m_held = 1;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic check_model();
    logic [4:0] eg;
    logic [2:0] es;
    eg = (m_own < 0) ? 5'b0 : (5'b1 << m_own);
    es = (m_own < 0) ? 3'b111 : 3'(m_own);
    chk("model_grant", 32'(grant), 32'(eg));
    chk("model_bus_sel", 32'(bus_sel), 32'(es));
    chk("model_busy", 32'(bus_busy), 32'(m_own >= 0));
  endtask

  // One clock: drive at negedge, model at posedge, compare at negedge.
  task automatic cycle(input logic [4:0] r, input logic lk);
    req  = r;
    lock = lk;
    @(posedge clk);
    if (rst_n) model_step(r, lk);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    lock = 1'b0;
    #1;
    model_reset();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_sel", 32'(bus_sel), 32'h7);
    chk("rst_busy", 32'(bus_busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0;
    lock = 1'b0;
    model_reset();
    @(negedge clk);

    // Held in reset with random requests: outputs stay cleared.
    for (int i = 0; i < 3; i++) begin
      cycle(5'($urandom_range(0, 31)), 1'b0);
      chk("t1_grant", 32'(grant), 32'h0);
      chk("t1_sel", 32'(bus_sel), 32'h7);
    end
    rst_n = 1'b1;

    // Sole requester 0 held 20 cycles, then idle.
    cycle(5'b00001, 1'b0);
    chk("t2_grant", 32'(grant), 32'h01);
    chk("t2_sel", 32'(bus_sel), 32'h0);
    for (int i = 0; i < 20; i++) cycle(5'b00001, 1'b0);
    chk("t2_hold_grant", 32'(grant), 32'h01);
    cycle(5'b00000, 1'b0);
    chk("t2_idle_grant", 32'(grant), 32'h0);
    chk("t2_idle_sel", 32'(bus_sel), 32'h7);

    // All requesting: 0,1,2,3,4,0,... four cycles each.
    do_reset();
    for (int k = 0; k < 40; k++) begin
      cycle(5'b11111, 1'b0);
      chk("t3_rotation", 32'(grant), 32'(5'b1 << ((k / 4) % 5)));
    end

    // PC releases on the edge MAR requests: no idle gap.
    do_reset();
    cycle(5'b00010, 1'b0);
    chk("t4_pc", 32'(grant), 32'h02);
    cycle(5'b00010, 1'b0);
    cycle(5'b01000, 1'b0);
    chk("t4_mar", 32'(grant), 32'h08);
    chk("t4_mar_sel", 32'(bus_sel), 32'h3);

    // Release with new arrivals: search starts after departing owner.
    do_reset();
    cycle(5'b00001, 1'b0);
    cycle(5'b01100, 1'b0);
    chk("t_rel_new", 32'(grant), 32'h04);

    // Long sole ownership, then a waiter appears: yields next edge.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(5'b00010, 1'b0);
    chk("t_sole", 32'(grant), 32'h02);
    cycle(5'b00011, 1'b0);
    chk("t_sole_yield", 32'(grant), 32'h01);

`ifdef ARB_LOCK_EN
    // IR locked for 10 cycles with MEMORY waiting, then unlock.
    do_reset();
    cycle(5'b00100, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle(5'b10100, 1'b1);
      chk("t5_locked", 32'(grant), 32'h04);
    end
    cycle(5'b10100, 1'b0);
    chk("t5_mem", 32'(grant), 32'h10);
    chk("t5_mem_sel", 32'(bus_sel), 32'h4);
`endif

    // MEMORY owner, reset asserted mid-cycle clears outputs at once.
    do_reset();
    cycle(5'b10000, 1'b0);
    cycle(5'b10000, 1'b0);
    chk("t6_mem", 32'(grant), 32'h10);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_async_grant", 32'(grant), 32'h0);
    chk("t6_async_sel", 32'(bus_sel), 32'h7);
    chk("t6_async_busy", 32'(bus_busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(5'b00100, 1'b0);
    chk("t6_ir", 32'(grant), 32'h04);

    // Random traffic checked against the model.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic [4:0] r;
      r = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) r = 5'b0;
      cycle(r, $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
